// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key-schedule engine.
//   - key-length encodings and Nk / Nr lookups
//   - FSM state type
//   - AES S-box and GF(2^8) xtime helpers
package aes_pkg;

    localparam int MAX_NK_DEF = 8;
    localparam int MAX_NR_DEF = 14;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Element 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Reserved encoding 2'b11 falls through to the AES-128 values.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word   in  32  input word
//   result out 32  byte-wise substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    assign result = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key-schedule engine: expands one 32-bit word per clock into
// an internal word file, AES-128/192/256 selected per run by key_len.
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   start      in   1    run request, honoured only in IDLE
//   key_len    in   2    00=128, 01=192, 10=256, 11=treated as 128
//   key        in   256  cipher key, MSB-first, left-aligned
//   busy       out  1    run in progress (LOAD / EXPAND)
//   done       out  1    one-cycle pulse after the final word is written
//   key_valid  out  1    word file holds a complete schedule
//   nr         out  4    round count of the stored schedule
//   rk_idx     in   4    round-key index to read
//   rk_data    out  128  round key rk_idx, zero when invalid or out of range
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = MAX_NK_DEF,
    parameter int MAX_NR = MAX_NR_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [3:0]   nr,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data
);

    localparam int DEPTH = 4 * (MAX_NR + 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    kl;
    logic [255:0]  key_hold;
    logic [5:0]    idx;
    logic [2:0]    kmod;
    logic [7:0]    rcon;
    logic [31:0]   w [DEPTH];

    logic [3:0]    nk;
    logic [3:0]    nr_cur;
    logic [5:0]    last_idx;
    logic          last_word;
    logic          accept;
    logic [31:0]   temp;
    logic [31:0]   prev;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   new_word;
    logic [3:0]    rk_sel;
    logic [5:0]    rk_base;

    assign nk        = nk_of(kl);
    assign nr_cur    = nr_of(kl);
    assign last_idx  = {nr_cur, 2'b00} + 6'd3;
    assign last_word = (idx == last_idx);
    assign accept    = (state == S_IDLE) && start;

    assign temp = w[idx - 6'd1];
    assign prev = w[idx - {2'b00, nk}];

    // Single S-box bank shared by the RotWord path (i%Nk==0) and the
    // AES-256 mid-key path (i%Nk==4).
    assign sub_in = (kmod == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    aes_sub_word u_sub_word (
        .word   (sub_in),
        .result (sub_out)
    );

    always_comb begin
        new_word = prev ^ temp;
        if (kmod == 3'd0) begin
            new_word = prev ^ sub_out ^ {rcon, 24'h000000};
        end else if ((nk == 4'd8) && (kmod == 3'd4)) begin
            new_word = prev ^ sub_out;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   state_next = S_EXPAND;
            S_EXPAND: if (last_word) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_LOAD, S_EXPAND: busy = 1'b1;
            S_DONE:           done = 1'b1;
            default:          ;
        endcase
    end

    // Control datapath: run parameters, word index, modulo counter, rcon.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kl        <= KL_128;
            key_hold  <= '0;
            idx       <= '0;
            kmod      <= '0;
            rcon      <= '0;
            nr        <= '0;
            key_valid <= 1'b0;
        end else begin
            if (accept) begin
                kl        <= (key_len == 2'b11) ? KL_128 : key_len;
                key_hold  <= key;
                key_valid <= 1'b0;
            end
            if (state == S_LOAD) begin
                idx  <= {2'b00, nk};
                kmod <= '0;
                rcon <= 8'h01;
            end
            if (state == S_EXPAND) begin
                if (last_word) begin
                    // Publish on entry to DONE so the schedule is readable
                    // in the same cycle as the done pulse.
                    key_valid <= 1'b1;
                    nr        <= nr_cur;
                end else begin
                    idx <= idx + 6'd1;
                end
                kmod <= ({1'b0, kmod} == (nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
                if (kmod == 3'd0) begin
                    rcon <= xtime(rcon);
                end
            end
        end
    end

    // Word file is not reset; every read is gated by key_valid.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int j = 0; j < MAX_NK; j++) begin
                w[j] <= key_hold[255 - 32*j -: 32];
            end
        end else if (state == S_EXPAND) begin
            w[idx] <= new_word;
        end
    end

    // Clamp keeps the address in range for rk_idx=15; the result is zeroed anyway.
    assign rk_sel  = (rk_idx > 4'(MAX_NR)) ? 4'(MAX_NR) : rk_idx;
    assign rk_base = {rk_sel, 2'b00};

    always_comb begin
        rk_data = '0;
        if (key_valid && (rk_idx <= nr)) begin
            rk_data = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;

    aes_key_schedule_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .nr        (nr),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int n_cmp = 0;
    int n_err = 0;

    // sel 0..3 picks one word of the round key, sel 4 compares all 128 bits.
    typedef struct packed {
        logic [3:0]   idx;
        logic [2:0]   sel;
        logic [127:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] idx, input logic [2:0] sel,
                        input logic [127:0] val);
        exp_t e;
        e.idx = idx;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t         e;
        string        t;
        logic [127:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            rk_idx = e.idx;
            #1;
            if (e.sel == 3'd4) obs = rk_data;
            else               obs = {96'h0, rk_data[127 - 32*e.sel -: 32]};
            check(t, obs, e.val);
        end
    endtask

    // Starts a run and waits (bounded) for done. Cycle 1 is the cycle after the
    // accepting edge. inj_cyc injects a competing AES-256 start mid-run;
    // start_in_done raises start during the done cycle.
    task automatic run(input logic [1:0] kl, input logic [255:0] k, input int inj_cyc,
                       input bit start_in_done, output int lat);
        int cyc;
        @(posedge clk); #1;
        key_len = kl;
        key     = k;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        check("busy_after_accept", 128'(busy), 128'd1);
        check("key_valid_cleared", 128'(key_valid), 128'd0);
        while (!done && cyc < 200) begin
            if (cyc == inj_cyc) begin
                start   = 1'b1;
                key_len = 2'b10;
                key     = KEY_A3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        lat = done ? cyc : -1;
        if (start_in_done && done) begin
            start   = 1'b1;
            key_len = 2'b10;
            key     = KEY_A3;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_busy", 128'(busy), 128'd0);
            check("start_in_done_kv", 128'(key_valid), 128'd1);
        end
    endtask

    initial begin
        int lat;
        int cyc;
        bit seen;

        rst     = 1'b1;
        start   = 1'b0;
        key_len = 2'b00;
        key     = '0;
        rk_idx  = 4'd0;
        #2;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_key_valid", 128'(key_valid), 128'd0);
        check("rst_nr", 128'(nr), 128'd0);
        check("rst_rk_data", rk_data, 128'd0);
        #6;
        rst = 1'b0;

        // AES-128, FIPS-197 A.1, with a start raised in the DONE cycle
        push("a1_rk0", 4'd0, 3'd4, KEY_A1[255:128]);
        push("a1_w4", 4'd1, 3'd0, 128'h a0fafe17);
        push("a1_rk10", 4'd10, 3'd4, RK10_A1);
        run(2'b00, KEY_A1, -1, 1'b1, lat);
        check("a1_latency", 128'(lat), 128'd42);
        check("a1_nr", 128'(nr), 128'd10);
        drain();

        // Start at cycle 10 of an AES-128 run must be ignored
        push("b2b_w4", 4'd1, 3'd0, 128'h a0fafe17);
        push("b2b_rk10", 4'd10, 3'd4, RK10_A1);
        run(2'b00, KEY_A1, 10, 1'b0, lat);
        check("b2b_latency", 128'(lat), 128'd42);
        check("b2b_nr", 128'(nr), 128'd10);
        drain();

        // Reset at cycle 20 of a run
        @(posedge clk); #1;
        key_len = 2'b00;
        key     = KEY_A1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        rst    = 1'b1;
        rk_idx = 4'd0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_key_valid", 128'(key_valid), 128'd0);
        check("abort_rk_data", rk_data, 128'd0);
        #2;
        rst = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 128'(seen), 128'd0);

        // AES-192, FIPS-197 A.2
        push("a2_rk0", 4'd0, 3'd4, KEY_A2[255:128]);
        push("a2_w6", 4'd1, 3'd2, 128'h fe0c91f7);
        push("a2_w51", 4'd12, 3'd3, 128'h 01002202);
        push("a2_rk13_zero", 4'd13, 3'd4, 128'd0);
        run(2'b01, KEY_A2, -1, 1'b0, lat);
        check("a2_latency", 128'(lat), 128'd48);
        check("a2_nr", 128'(nr), 128'd12);
        drain();

        // AES-256, FIPS-197 A.3
        push("a3_w12", 4'd3, 3'd0, 128'h a8b09c1a);
        push("a3_w59", 4'd14, 3'd3, 128'h 706c631e);
        push("a3_rk15_zero", 4'd15, 3'd4, 128'd0);
        run(2'b10, KEY_A3, -1, 1'b0, lat);
        check("a3_latency", 128'(lat), 128'd54);
        check("a3_nr", 128'(nr), 128'd14);
        drain();

        // Switch back to AES-128
        push("sw_rk10", 4'd10, 3'd4, RK10_A1);
        push("sw_rk11_zero", 4'd11, 3'd4, 128'd0);
        run(2'b00, KEY_A1, -1, 1'b0, lat);
        check("sw_latency", 128'(lat), 128'd42);
        check("sw_nr", 128'(nr), 128'd10);
        drain();

        // Reserved key_len behaves as AES-128
        push("kl11_w4", 4'd1, 3'd0, 128'h a0fafe17);
        push("kl11_rk10", 4'd10, 3'd4, RK10_A1);
        push("kl11_rk11_zero", 4'd11, 3'd4, 128'd0);
        run(2'b11, KEY_A1, -1, 1'b0, lat);
        check("kl11_latency", 128'(lat), 128'd42);
        check("kl11_nr", 128'(nr), 128'd10);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
